// File: rtl/dbus_master_if.sv
// Bus bundle for dbus_master: CPU data-access side and Wishbone classic master side.
// The master modport is the dbus_master view; the slave modport is everything around it.
interface dbus_master_if;
  // CPU side
  logic        cpu_cyc;
  logic        cpu_we;
  logic [31:0] cpu_adr;
  logic [31:0] cpu_dat_o;
  logic [3:0]  cpu_sel;
  logic        cpu_ack;
  logic [31:0] cpu_dat_i;
  logic        cpu_err;

  // Wishbone side
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [31:0] wb_dat_i;

  // FSM state for observation
  logic [1:0]  dbg_state;

  modport master (
    input  cpu_cyc, cpu_we, cpu_adr, cpu_dat_o, cpu_sel,
    output cpu_ack, cpu_dat_i, cpu_err,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_ack_i, wb_err_i, wb_dat_i,
    output dbg_state
  );

  modport slave (
    output cpu_cyc, cpu_we, cpu_adr, cpu_dat_o, cpu_sel,
    input  cpu_ack, cpu_dat_i, cpu_err,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_ack_i, wb_err_i, wb_dat_i,
    input  dbg_state
  );
endinterface

// File: rtl/dbus_master.sv
// Memory-stage data bus master: turns a held CPU request into one Wishbone classic
// cycle with byte-lane steering, load alignment, bus-error and timeout reporting.
module dbus_master #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic clk_i,
  input  logic rst_i,
  dbus_master_if.master bus
);

  // Handshake: cpu_cyc is a request held stable until the one-cycle cpu_ack strobe;
  // cpu_err and cpu_dat_i are meaningful with cpu_ack and hold until the next one.
  // On Wishbone, a cycle ends on the first sampled wb_ack_i or wb_err_i (err wins).
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = TIMEOUT - 8'd1;

  state_t      state, state_next;
  logic [7:0]  cnt, cnt_next;
  logic        err_flag, err_next;
  logic        we_q, we_next;
  logic [31:0] adr_q, adr_next;
  logic [31:0] wdat_q, wdat_next;
  logic [3:0]  sel_q, sel_next;
  logic [31:0] rdat_q, rdat_next;
  logic        cyc_q;
  logic        ack_q;

  function automatic logic [31:0] steer_wdata(input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] r;
    case (sel)
      4'b1111:                            r = d;
      4'b1100, 4'b0011:                   r = {2{d[15:0]}};
      4'b1000, 4'b0100, 4'b0010, 4'b0001: r = {4{d[7:0]}};
      default:                            r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] align_rdata(input logic [3:0] sel, input logic [31:0] d);
    logic [31:0] r;
    case (sel)
      4'b1111: r = d;
      4'b1100: r = {16'h0000, d[31:16]};
      4'b0011: r = {16'h0000, d[15:0]};
      4'b1000: r = {24'h000000, d[31:24]};
      4'b0100: r = {24'h000000, d[23:16]};
      4'b0010: r = {24'h000000, d[15:8]};
      4'b0001: r = {24'h000000, d[7:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    err_next   = err_flag;
    we_next    = we_q;
    adr_next   = adr_q;
    wdat_next  = wdat_q;
    sel_next   = sel_q;
    rdat_next  = rdat_q;
    case (state)
      IDLE: begin
        if (bus.cpu_cyc) begin
          we_next    = bus.cpu_we;
          adr_next   = bus.cpu_adr;
          sel_next   = bus.cpu_sel;
          wdat_next  = steer_wdata(bus.cpu_sel, bus.cpu_dat_o);
          cnt_next   = 8'd0;
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (bus.wb_err_i) begin
          err_next   = 1'b1;
          rdat_next  = 32'd0;
          state_next = RESP;
        end else if (bus.wb_ack_i) begin
          err_next   = 1'b0;
          rdat_next  = we_q ? 32'd0 : align_rdata(sel_q, bus.wb_dat_i);
          state_next = RESP;
        end else if ((TIMEOUT != 8'd0) && (cnt == TMO_LAST)) begin
          // The TIMEOUT-th silent cycle ends the bus cycle as an error.
          err_next   = 1'b1;
          rdat_next  = 32'd0;
          state_next = RESP;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bus and response outputs are registered from the next state, so they line up
  // exactly with the state they belong to without any decode glitches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt      <= 8'd0;
      err_flag <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= 32'd0;
      wdat_q   <= 32'd0;
      sel_q    <= 4'd0;
      rdat_q   <= 32'd0;
      cyc_q    <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      err_flag <= err_next;
      we_q     <= we_next;
      adr_q    <= adr_next;
      wdat_q   <= wdat_next;
      sel_q    <= sel_next;
      rdat_q   <= rdat_next;
      cyc_q    <= (state_next == ACTIVE);
      ack_q    <= (state_next == RESP);
    end
  end

  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = wdat_q;
  assign bus.wb_sel_o  = sel_q;
  assign bus.cpu_ack   = ack_q;
  assign bus.cpu_dat_i = rdat_q;
  assign bus.cpu_err   = err_flag;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_dbus_master.sv
// Self-checking bench for dbus_master (TIMEOUT=4): directed transactions, a Wishbone
// slave responder, and a per-cycle compare process against a transaction-level model.
module tb_dbus_master;

  logic clk;
  logic rst;
  logic rst_seen = 1'b1;

  dbus_master_if bus();

  dbus_master #(.TIMEOUT(8'd4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) rst_seen <= rst;

  // ---------------- scoreboard state ----------------
  int          n_vec  = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];          // {err, data} expected at each cpu_ack
  logic        req_we;
  logic [31:0] req_adr;
  logic [31:0] req_dat;
  logic [3:0]  req_sel;
  logic [31:0] last_dat;
  logic        last_err;

  int          slv_delay;
  logic        slv_ack;
  logic        slv_err;
  logic [31:0] slv_dat;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model_wdata(input logic [3:0] sel, input logic [31:0] d);
    int n;
    n = $countones(sel);
    if (sel == 4'hf) return d;
    if (sel == 4'hc || sel == 4'h3) return {2{d[15:0]}};
    if (n == 1) return {4{d[7:0]}};
    return d;
  endfunction

  // Selected lanes form a contiguous field: shift it down and keep n bytes.
  function automatic logic [31:0] model_rdata(input logic [3:0] sel, input logic [31:0] d);
    int n;
    int lsb;
    logic [63:0] mask;
    n = $countones(sel);
    if (!(sel == 4'hf || sel == 4'hc || sel == 4'h3 || n == 1)) return d;
    lsb = 0;
    for (int i = 3; i >= 0; i--) if (sel[i]) lsb = i;
    mask = (64'd1 << (8 * n)) - 64'd1;
    return 32'((64'(d) >> (8 * lsb)) & mask);
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic [32:0] e;
    last_dat = 32'd0;
    last_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        check1("rst_wb_cyc", bus.wb_cyc_o, 1'b0);
        check1("rst_wb_stb", bus.wb_stb_o, 1'b0);
        check1("rst_wb_we", bus.wb_we_o, 1'b0);
        check1("rst_cpu_ack", bus.cpu_ack, 1'b0);
        check1("rst_cpu_err", bus.cpu_err, 1'b0);
        check32("rst_wb_adr", bus.wb_adr_o, 32'd0);
        check32("rst_wb_dat", bus.wb_dat_o, 32'd0);
        check32("rst_wb_sel", {28'd0, bus.wb_sel_o}, 32'd0);
        check32("rst_cpu_dat_i", bus.cpu_dat_i, 32'd0);
        check32("rst_state", {30'd0, bus.dbg_state}, 32'd0);
        last_dat = 32'd0;
        last_err = 1'b0;
      end else begin
        check1("stb_follows_cyc", bus.wb_stb_o, bus.wb_cyc_o);
        if (bus.wb_cyc_o) begin
          check1("wb_we", bus.wb_we_o, req_we);
          check32("wb_adr", bus.wb_adr_o, req_adr);
          check32("wb_sel", {28'd0, bus.wb_sel_o}, {28'd0, req_sel});
          check32("wb_dat", bus.wb_dat_o, model_wdata(req_sel, req_dat));
        end
        if (bus.cpu_ack) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_cpu_ack: got ack=1 expected no response at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            last_dat = e[31:0];
            last_err = e[32];
          end
        end
        check32("cpu_dat_i", bus.cpu_dat_i, last_dat);
        check1("cpu_err", bus.cpu_err, last_err);
      end
    end
  end

  // ---------------- Wishbone slave responder ----------------
  initial begin
    int active_n;
    active_n = 0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_dat_i = 32'd0;
    forever begin
      @(negedge clk);
      if (bus.wb_cyc_o && !rst) begin
        if (active_n == slv_delay) begin
          bus.wb_ack_i = slv_ack;
          bus.wb_err_i = slv_err;
          bus.wb_dat_i = slv_dat;
        end else begin
          bus.wb_ack_i = 1'b0;
          bus.wb_err_i = 1'b0;
          bus.wb_dat_i = 32'h0BAD_F00D;
        end
        active_n++;
      end else begin
        active_n = 0;
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge; cycle 1 is the cycle cpu_cyc is first presented.
  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int delay, input logic ack, input logic err,
                     input logic [31:0] sdat, input logic keep, input logic drop_early,
                     output int n_cyc, output int ack_at, output logic [31:0] seen_wdat);
    logic timed_out;
    slv_delay = delay;
    slv_ack   = ack;
    slv_err   = err;
    slv_dat   = sdat;
    req_we    = we;
    req_adr   = adr;
    req_dat   = dat;
    req_sel   = sel;
    timed_out = (!ack && !err) || (delay >= 4);
    if (timed_out || err) exp_q.push_back({1'b1, 32'd0});
    else if (we)          exp_q.push_back({1'b0, 32'd0});
    else                  exp_q.push_back({1'b0, model_rdata(sel, sdat)});
    bus.cpu_cyc   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_adr   = adr;
    bus.cpu_dat_o = dat;
    bus.cpu_sel   = sel;
    n_cyc = 0;
    ack_at = -1;
    seen_wdat = 32'd0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.wb_cyc_o) begin
        n_cyc++;
        seen_wdat = bus.wb_dat_o;
      end
      if (bus.cpu_ack) ack_at = c;
      @(posedge clk);
      #1;
      if (drop_early) bus.cpu_cyc = 1'b0;
      if (ack_at >= 0) break;
    end
    if (!keep) bus.cpu_cyc = 1'b0;
    if (ack_at < 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL txn_no_ack: got no cpu_ack expected one within 40 cycles at %0t", $time);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int a;
    logic [31:0] w;
    rst           = 1'b1;
    bus.cpu_cyc   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_adr   = 32'd0;
    bus.cpu_dat_o = 32'd0;
    bus.cpu_sel   = 4'd0;
    slv_delay = 1000; slv_ack = 1'b0; slv_err = 1'b0; slv_dat = 32'd0;
    req_we = 1'b0; req_adr = 32'd0; req_dat = 32'd0; req_sel = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Word load, zero-wait slave.
    txn(1'b0, 32'h100, 32'd0, 4'b1111, 0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, n, a, w);
    check_int("word_load_cyc_len", n, 1);
    check_int("word_load_ack_cycle", a, 3);
    check32("word_load_dat", bus.cpu_dat_i, 32'hDEADBEEF);
    check1("word_load_err", bus.cpu_err, 1'b0);

    // Load alignment across lane patterns.
    txn(1'b0, 32'h204, 32'd0, 4'b0100, 0, 1'b1, 1'b0, 32'h11223344, 1'b0, 1'b0, n, a, w);
    check32("byte_load_0100", bus.cpu_dat_i, 32'h00000022);
    txn(1'b0, 32'h206, 32'd0, 4'b0011, 0, 1'b1, 1'b0, 32'h11223344, 1'b0, 1'b0, n, a, w);
    check32("half_load_0011", bus.cpu_dat_i, 32'h00003344);
    txn(1'b0, 32'h208, 32'd0, 4'b1100, 1, 1'b1, 1'b0, 32'h11223344, 1'b0, 1'b0, n, a, w);
    check32("half_load_1100", bus.cpu_dat_i, 32'h00001122);
    txn(1'b0, 32'h20C, 32'd0, 4'b1000, 0, 1'b1, 1'b0, 32'hA1B2C3D4, 1'b0, 1'b0, n, a, w);
    check32("byte_load_1000", bus.cpu_dat_i, 32'h000000A1);
    txn(1'b0, 32'h20F, 32'd0, 4'b0001, 0, 1'b1, 1'b0, 32'hA1B2C3D4, 1'b0, 1'b0, n, a, w);
    check32("byte_load_0001", bus.cpu_dat_i, 32'h000000D4);
    txn(1'b0, 32'h210, 32'd0, 4'b0110, 0, 1'b1, 1'b0, 32'hA1B2C3D4, 1'b0, 1'b0, n, a, w);
    check32("odd_load_0110", bus.cpu_dat_i, 32'hA1B2C3D4);

    // Stores: lane steering, zero read data.
    txn(1'b1, 32'h300, 32'h000000A5, 4'b0010, 0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, n, a, w);
    check32("byte_store_wdat", w, 32'hA5A5A5A5);
    check32("byte_store_dat_i", bus.cpu_dat_i, 32'd0);
    txn(1'b1, 32'h304, 32'h1234BEEF, 4'b1100, 0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, n, a, w);
    check32("half_store_wdat", w, 32'hBEEFBEEF);
    txn(1'b1, 32'h308, 32'h12345678, 4'b0110, 0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, n, a, w);
    check32("odd_store_wdat", w, 32'h12345678);

    // Silent slave: timeout after four ACTIVE cycles.
    txn(1'b0, 32'h400, 32'd0, 4'b1111, 1000, 1'b0, 1'b0, 32'h55555555, 1'b0, 1'b0, n, a, w);
    check_int("timeout_cyc_len", n, 4);
    check_int("timeout_ack_cycle", a, 6);
    check1("timeout_err", bus.cpu_err, 1'b1);
    check32("timeout_dat", bus.cpu_dat_i, 32'd0);

    // Simultaneous ack and err: error wins.
    txn(1'b0, 32'h404, 32'd0, 4'b1111, 1, 1'b1, 1'b1, 32'h77777777, 1'b0, 1'b0, n, a, w);
    check_int("ackerr_cyc_len", n, 2);
    check1("ackerr_err", bus.cpu_err, 1'b1);

    // Ack on the last cycle before the timeout still succeeds and clears the error.
    txn(1'b0, 32'h408, 32'd0, 4'b1111, 3, 1'b1, 1'b0, 32'h0F1E2D3C, 1'b0, 1'b0, n, a, w);
    check_int("late_ack_cyc_len", n, 4);
    check1("late_ack_err", bus.cpu_err, 1'b0);
    check32("late_ack_dat", bus.cpu_dat_i, 32'h0F1E2D3C);

    // cpu_cyc held across cpu_ack: next bus cycle only after one IDLE cycle.
    txn(1'b0, 32'h500, 32'd0, 4'b1111, 0, 1'b1, 1'b0, 32'h01020304, 1'b1, 1'b0, n, a, w);
    txn(1'b0, 32'h500, 32'd0, 4'b1111, 0, 1'b1, 1'b0, 32'h01020304, 1'b0, 1'b0, n, a, w);
    check_int("held_req_ack_cycle", a, 3);
    check_int("held_req_cyc_len", n, 1);

    // cpu_cyc dropped during ACTIVE: bus cycle still completes.
    txn(1'b0, 32'h600, 32'd0, 4'b0001, 2, 1'b1, 1'b0, 32'h000000C7, 1'b0, 1'b1, n, a, w);
    check_int("drop_cyc_len", n, 3);
    check_int("drop_ack_cycle", a, 5);

    // Reset during ACTIVE abandons the transaction.
    slv_delay = 1000; slv_ack = 1'b0; slv_err = 1'b0;
    req_we = 1'b0; req_adr = 32'h700; req_dat = 32'd0; req_sel = 4'b1111;
    bus.cpu_cyc = 1'b1; bus.cpu_we = 1'b0; bus.cpu_adr = 32'h700; bus.cpu_sel = 4'b1111;
    @(posedge clk);
    #1;
    check1("abort_pre_cyc", bus.wb_cyc_o, 1'b1);
    rst = 1'b1;
    bus.cpu_cyc = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check1("abort_cyc", bus.wb_cyc_o, 1'b0);
    check1("abort_ack", bus.cpu_ack, 1'b0);
    repeat (6) @(posedge clk);
    #1;

    // Recovery after reset.
    txn(1'b0, 32'h800, 32'd0, 4'b0010, 0, 1'b1, 1'b0, 32'hCAFEBABE, 1'b0, 1'b0, n, a, w);
    check32("recover_dat", bus.cpu_dat_i, 32'h000000BA);

    repeat (3) @(posedge clk);
    #1;
    check_int("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
